// File: rtl/seletor_minigame_pkg.sv
// rtl/seletor_minigame_pkg.sv - shared menu state codes, mux select and game indices
package seletor_minigame_pkg;

   typedef enum logic [3:0] {
      ESTADO_INICIAL  = 4'h0,
      ESTADO_MENU     = 4'h1,
      ESTADO_CONFIRMA = 4'h2,
      ESTADO_JOGANDO  = 4'h3,
      ESTADO_FIM      = 4'h4
   } estado_t;

   localparam logic [1:0] MINIGAME_MENU = 2'b11;
   localparam logic [1:0] JOGO_0        = 2'd0;
   localparam logic [1:0] JOGO_1        = 2'd1;
   localparam logic [1:0] JOGO_2        = 2'd2;

endpackage

// File: rtl/seletor_minigame_detector_borda.sv
// rtl/seletor_minigame_detector_borda.sv - single-bit rising-edge detector
module detector_borda (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic nivel_i,
   output logic pulso_o
);

   logic anterior_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) anterior_q <= 1'b0;
      else         anterior_q <= nivel_i;
   end

   assign pulso_o = nivel_i & ~anterior_q;

endmodule

// File: rtl/seletor_minigame.sv
// rtl/seletor_minigame.sv - minigame menu/selection controller; AUTO_RETURN_EN adds FIM timeout
module seletor_minigame
   import seletor_minigame_pkg::*;
#(
   parameter int N_JOGOS       = 3,
   parameter int TEMPO_FIM     = 5000,
   parameter int LARGURA_TEMPO = 13
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       botao_proximo,
   input  logic       botao_anterior,
   input  logic       botao_confirma,
   input  logic       botao_voltar,
   input  logic       pronto,
   output logic [1:0] minigame,
   output logic [3:0] estado_inicial,
   output logic [1:0] cursor,
   output logic       iniciar_jogo,
   output logic       reset_jogos
);

   if (N_JOGOS < 1 || N_JOGOS > 3 || TEMPO_FIM < 1 || (TEMPO_FIM >> LARGURA_TEMPO) != 0) begin : g_param_invalido
      $error("seletor_minigame: invalid N_JOGOS/TEMPO_FIM/LARGURA_TEMPO");
   end

   estado_t    estado_q, estado_d;
   logic [1:0] cursor_q, cursor_d;
   logic [1:0] minigame_q, minigame_d;
   logic       iniciar_q, iniciar_d;
   logic       reset_jogos_q, reset_jogos_d;
   logic       p_prox, p_ant, p_conf, p_volt;
   logic       s_prox, s_ant, s_conf, s_volt;
   logic       em_jogo;
   logic       fim_timeout;

   detector_borda u_borda_prox (.clk_i(clock), .rst_ni(reset), .nivel_i(botao_proximo),  .pulso_o(p_prox));
   detector_borda u_borda_ant  (.clk_i(clock), .rst_ni(reset), .nivel_i(botao_anterior), .pulso_o(p_ant));
   detector_borda u_borda_conf (.clk_i(clock), .rst_ni(reset), .nivel_i(botao_confirma), .pulso_o(p_conf));
   detector_borda u_borda_volt (.clk_i(clock), .rst_ni(reset), .nivel_i(botao_voltar),   .pulso_o(p_volt));

   // Only the highest-priority pulse of a cycle survives.
   assign s_volt = p_volt;
   assign s_conf = p_conf & ~p_volt;
   assign s_prox = p_prox & ~p_volt & ~p_conf;
   assign s_ant  = p_ant  & ~p_volt & ~p_conf & ~p_prox;

`ifdef AUTO_RETURN_EN
   logic [LARGURA_TEMPO-1:0] timer_q, timer_d;
   assign fim_timeout = (timer_q == LARGURA_TEMPO'(TEMPO_FIM - 1));
`else
   assign fim_timeout = 1'b0;
`endif

   always_comb begin
      estado_d  = estado_q;
      cursor_d  = cursor_q;
      iniciar_d = 1'b0;
`ifdef AUTO_RETURN_EN
      timer_d   = timer_q;
`endif
      case (estado_q)
         ESTADO_INICIAL: begin
            if (s_prox || s_ant || s_conf) estado_d = ESTADO_MENU;
         end
         ESTADO_MENU: begin
            if (s_volt) begin
               estado_d = ESTADO_INICIAL;
               cursor_d = JOGO_0;
            end else if (s_conf) begin
               estado_d = ESTADO_CONFIRMA;
            end else if (s_prox) begin
               cursor_d = (cursor_q >= 2'(N_JOGOS - 1)) ? JOGO_0 : cursor_q + 2'd1;
            end else if (s_ant) begin
               cursor_d = (cursor_q == JOGO_0 || cursor_q > 2'(N_JOGOS - 1)) ?
                          2'(N_JOGOS - 1) : cursor_q - 2'd1;
            end
         end
         ESTADO_CONFIRMA: begin
            if (s_volt) begin
               estado_d = ESTADO_MENU;
            end else if (s_conf) begin
               estado_d  = ESTADO_JOGANDO;
               iniciar_d = 1'b1;
            end
         end
         ESTADO_JOGANDO: begin
            if (s_volt) begin
               estado_d = ESTADO_MENU;
            end else if (pronto) begin
               estado_d = ESTADO_FIM;
`ifdef AUTO_RETURN_EN
               timer_d  = '0;
`endif
            end
         end
         ESTADO_FIM: begin
            if (s_volt || s_conf || fim_timeout) begin
               estado_d = ESTADO_MENU;
            end else begin
`ifdef AUTO_RETURN_EN
               timer_d = timer_q + LARGURA_TEMPO'(1);
`endif
            end
         end
         default: begin
            estado_d = ESTADO_INICIAL;
            cursor_d = JOGO_0;
         end
      endcase

      // The mux follows the game through FIM so the final score stays visible.
      em_jogo       = (estado_d == ESTADO_JOGANDO) || (estado_d == ESTADO_FIM);
      minigame_d    = em_jogo ? cursor_d : MINIGAME_MENU;
      reset_jogos_d = ~em_jogo;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q      <= ESTADO_INICIAL;
         cursor_q      <= JOGO_0;
         minigame_q    <= MINIGAME_MENU;
         iniciar_q     <= 1'b0;
         reset_jogos_q <= 1'b1;
`ifdef AUTO_RETURN_EN
         timer_q       <= '0;
`endif
      end else begin
         estado_q      <= estado_d;
         cursor_q      <= cursor_d;
         minigame_q    <= minigame_d;
         iniciar_q     <= iniciar_d;
         reset_jogos_q <= reset_jogos_d;
`ifdef AUTO_RETURN_EN
         timer_q       <= timer_d;
`endif
      end
   end

   assign estado_inicial = estado_q;
   assign cursor         = cursor_q;
   assign minigame       = minigame_q;
   assign iniciar_jogo   = iniciar_q;
   assign reset_jogos    = reset_jogos_q;

endmodule

// File: tb/tb_seletor_minigame.sv
// tb/tb_seletor_minigame.sv - directed vector bench for seletor_minigame
module tb_seletor_minigame;

   logic       clock = 1'b0;
   logic       reset;
   logic       bp, ba, bc, bv, pr;
   logic [1:0] minigame;
   logic [3:0] estado_inicial;
   logic [1:0] cursor;
   logic       iniciar_jogo;
   logic       reset_jogos;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [4:0] in;
      logic [9:0] exp;
   } vec_t;

   vec_t tab[$];

   always #5 clock = ~clock;

   seletor_minigame #(.N_JOGOS(3), .TEMPO_FIM(8), .LARGURA_TEMPO(4)) dut (
      .clock(clock), .reset(reset),
      .botao_proximo(bp), .botao_anterior(ba), .botao_confirma(bc), .botao_voltar(bv),
      .pronto(pr),
      .minigame(minigame), .estado_inicial(estado_inicial), .cursor(cursor),
      .iniciar_jogo(iniciar_jogo), .reset_jogos(reset_jogos)
   );

   localparam logic [4:0] NONE = 5'b00000;
   localparam logic [4:0] P    = 5'b10000;
   localparam logic [4:0] A    = 5'b01000;
   localparam logic [4:0] C    = 5'b00100;
   localparam logic [4:0] V    = 5'b00010;
   localparam logic [4:0] PR   = 5'b00001;

   function automatic logic [9:0] e(input logic [3:0] est, input logic [1:0] cur,
                                    input logic [1:0] mg, input logic ini, input logic rj);
      return {est, cur, mg, ini, rj};
   endfunction

   function automatic void add(input logic [4:0] in, input logic [9:0] exp);
      vec_t v;
      v.in  = in;
      v.exp = exp;
      tab.push_back(v);
   endfunction

   task automatic check(input string name, input logic [9:0] exp);
      logic [9:0] got;
      got = {estado_inicial, cursor, minigame, iniciar_jogo, reset_jogos};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got estado=%h cursor=%0d minigame=%b iniciar=%b reset_jogos=%b, expected estado=%h cursor=%0d minigame=%b iniciar=%b reset_jogos=%b",
                  name, got[9:6], got[5:4], got[3:2], got[1], got[0],
                  exp[9:6], exp[5:4], exp[3:2], exp[1], exp[0]);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic apply(input logic [4:0] in);
      {bp, ba, bc, bv, pr} = in;
      @(posedge clock);
      #1;
   endtask

   localparam logic [9:0] RST = 10'b0000_00_11_0_1;

   initial begin
      int cnt;
      reset = 1'b0;
      {bp, ba, bc, bv, pr} = NONE;

      add(P,      e(4'h1, 2'd0, 2'b11, 0, 1));
      add(NONE,   e(4'h1, 2'd0, 2'b11, 0, 1));
      add(P,      e(4'h1, 2'd1, 2'b11, 0, 1));
      add(NONE,   e(4'h1, 2'd1, 2'b11, 0, 1));
      add(P,      e(4'h1, 2'd2, 2'b11, 0, 1));
      add(NONE,   e(4'h1, 2'd2, 2'b11, 0, 1));
      add(P,      e(4'h1, 2'd0, 2'b11, 0, 1));
      add(NONE,   e(4'h1, 2'd0, 2'b11, 0, 1));
      add(A,      e(4'h1, 2'd2, 2'b11, 0, 1));
      add(NONE,   e(4'h1, 2'd2, 2'b11, 0, 1));
      add(A,      e(4'h1, 2'd1, 2'b11, 0, 1));
      add(NONE,   e(4'h1, 2'd1, 2'b11, 0, 1));
      add(C,      e(4'h2, 2'd1, 2'b11, 0, 1));
      add(NONE,   e(4'h2, 2'd1, 2'b11, 0, 1));
      add(P,      e(4'h2, 2'd1, 2'b11, 0, 1));
      add(NONE,   e(4'h2, 2'd1, 2'b11, 0, 1));
      add(C,      e(4'h3, 2'd1, 2'b01, 1, 0));
      add(NONE,   e(4'h3, 2'd1, 2'b01, 0, 0));
      add(PR,     e(4'h4, 2'd1, 2'b01, 0, 0));
      add(NONE,   e(4'h4, 2'd1, 2'b01, 0, 0));
      add(C,      e(4'h1, 2'd1, 2'b11, 0, 1));
      add(NONE,   e(4'h1, 2'd1, 2'b11, 0, 1));
      add(C,      e(4'h2, 2'd1, 2'b11, 0, 1));
      add(NONE,   e(4'h2, 2'd1, 2'b11, 0, 1));
      add(V,      e(4'h1, 2'd1, 2'b11, 0, 1));
      add(NONE,   e(4'h1, 2'd1, 2'b11, 0, 1));
      add(P|A|C|V, e(4'h0, 2'd0, 2'b11, 0, 1));
      add(NONE,   e(4'h0, 2'd0, 2'b11, 0, 1));
      add(P|A,    e(4'h1, 2'd0, 2'b11, 0, 1));
      add(NONE,   e(4'h1, 2'd0, 2'b11, 0, 1));
      add(P|A,    e(4'h1, 2'd1, 2'b11, 0, 1));
      add(NONE,   e(4'h1, 2'd1, 2'b11, 0, 1));
      add(A,      e(4'h1, 2'd0, 2'b11, 0, 1));
      add(NONE,   e(4'h1, 2'd0, 2'b11, 0, 1));
      add(A,      e(4'h1, 2'd2, 2'b11, 0, 1));
      add(NONE,   e(4'h1, 2'd2, 2'b11, 0, 1));
      add(C|P,    e(4'h2, 2'd2, 2'b11, 0, 1));
      add(NONE,   e(4'h2, 2'd2, 2'b11, 0, 1));
      add(C,      e(4'h3, 2'd2, 2'b10, 1, 0));
      add(NONE,   e(4'h3, 2'd2, 2'b10, 0, 0));
      add(V|PR,   e(4'h1, 2'd2, 2'b11, 0, 1));
      add(NONE,   e(4'h1, 2'd2, 2'b11, 0, 1));
      add(V,      e(4'h0, 2'd0, 2'b11, 0, 1));
      add(NONE,   e(4'h0, 2'd0, 2'b11, 0, 1));

      repeat (3) @(posedge clock);
      #1;
      check("reset_held", RST);
      reset = 1'b1;
      apply(NONE);
      check("reset_release", RST);

      for (int i = 0; i < tab.size(); i++) begin
         apply(tab[i].in);
         check($sformatf("vec%0d", i), tab[i].exp);
      end

      apply(P);
      apply(NONE);
      for (int i = 0; i < 20; i++) apply(P);
      check("hold_proximo", e(4'h1, 2'd1, 2'b11, 0, 1));
      apply(NONE);

      apply(C);
      apply(NONE);
      apply(C);
      check("launch_game1", e(4'h3, 2'd1, 2'b01, 1, 0));
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         apply(NONE);
         if (iniciar_jogo) cnt++;
      end
      check_int("iniciar_single_cycle", cnt, 0);
      check("jogando_hold", e(4'h3, 2'd1, 2'b01, 0, 0));

      apply(PR);
      check("enter_fim", e(4'h4, 2'd1, 2'b01, 0, 0));
`ifdef AUTO_RETURN_EN
      cnt = 0;
      for (int i = 0; i < 7; i++) begin
         apply(NONE);
         if (estado_inicial != 4'h4) cnt++;
      end
      check_int("fim_dwell", cnt, 0);
      apply(NONE);
      check("fim_auto_return", e(4'h1, 2'd1, 2'b11, 0, 1));
`else
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         apply(NONE);
         if (estado_inicial != 4'h4) cnt++;
      end
      check_int("fim_stays", cnt, 0);
      apply(V);
      check("fim_voltar", e(4'h1, 2'd1, 2'b11, 0, 1));
`endif
      apply(NONE);

      apply(C);
      apply(NONE);
      apply(C);
      apply(NONE);
      check("relaunch", e(4'h3, 2'd1, 2'b01, 0, 0));
      @(negedge clock);
      #2 reset = 1'b0;
      #1 check("async_reset", RST);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      apply(NONE);
      check("after_reset", RST);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seletor_minigame.md
Name: seletor_minigame

Overview:
- Menu/selection controller sitting directly upstream of the minigame output multiplexer.
- Drives its 2-bit `minigame` select and the 4-bit `estado_inicial` menu-state code.
- Lets the player browse the three minigames, confirm one, launch it, and observe its completion.
- Returns to the menu when the game finishes.

Parameters:
- N_JOGOS, 3: number of selectable minigames; cursor range 0..N_JOGOS-1, max 3.
- TEMPO_FIM, 5000: clock cycles the result stays displayed in FIM before auto-return (AUTO_RETURN_EN only).
- LARGURA_TEMPO, 13: width of the FIM timer; must satisfy 2^LARGURA_TEMPO > TEMPO_FIM.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- botao_proximo  in  1  raw level, advance cursor.
- botao_anterior  in  1  raw level, move cursor back.
- botao_confirma  in  1  raw level, confirm/launch.
- botao_voltar  in  1  raw level, return to menu.
- pronto  in  1  game-finished flag from the multiplexer's `pronto_out`.
- minigame  out  2  mux select; 2'b11 = menu, otherwise the index of the selected game.
- estado_inicial  out  4  menu state code for display.
- cursor  out  2  currently highlighted game.
- iniciar_jogo  out  1  one-cycle start pulse to the selected minigame.
- reset_jogos  out  1  high holds all minigames in reset.

Behaviour:
- Reset (reset=0, async): state INICIAL, cursor=0, minigame=2'b11, estado_inicial=4'h0, iniciar_jogo=0, reset_jogos=1, timer=0, edge registers=0.
- All buttons pass through a rising-edge detector: previous level registered, pulse = level & ~prev. Only pulses are used; holding a button never repeats.
- All outputs are registered. Latency is one cycle from a button edge pulse to the state/output change.
- States and estado_inicial codes: INICIAL=4'h0, MENU=4'h1, CONFIRMA=4'h2, JOGANDO=4'h3, FIM=4'h4. Unused codes go to INICIAL.
- INICIAL:
  - any proximo/anterior/confirma pulse -> MENU.
- MENU:
  - proximo: cursor = (cursor==N_JOGOS-1) ? 0 : cursor+1.
  - anterior: cursor = (cursor==0) ? N_JOGOS-1 : cursor-1.
  - confirma -> CONFIRMA.
  - voltar -> INICIAL, cursor=0.
- CONFIRMA:
  - confirma -> JOGANDO: minigame=cursor, reset_jogos=0, and iniciar_jogo=1 for exactly that one cycle.
  - voltar -> MENU.
  - proximo/anterior are ignored.
- JOGANDO:
  - minigame holds cursor.
  - pronto=1 -> FIM, timer cleared.
  - voltar -> MENU: minigame=2'b11, reset_jogos=1.
  - voltar takes priority over a simultaneous pronto.
- FIM:
  - minigame still equals cursor so the score stays visible through the mux; reset_jogos=0.
  - Exit condition depends on AUTO_RETURN_EN (see Optional Feature).
  - On exit: -> MENU, minigame=2'b11, reset_jogos=1, cursor preserved.
- minigame is 2'b11 in every state except JOGANDO and FIM. reset_jogos=1 in every state except JOGANDO and FIM.
- Simultaneous button pulses in one cycle, priority: voltar > confirma > proximo > anterior. The lower-priority pulses are dropped.
- Reset asserted mid-game: immediate return to the reset values; the game is held in reset via reset_jogos=1.
- cursor never takes a value ≥ N_JOGOS.

Optional Feature:
- Macro AUTO_RETURN_EN.
- Defined: FIM counts 0..TEMPO_FIM-1 and leaves on timer==TEMPO_FIM-1, or earlier on a confirma/voltar pulse.
- Undefined: no timer logic; FIM leaves only on a confirma or voltar pulse. TEMPO_FIM and LARGURA_TEMPO are unused.

Decomposition:
- Shared package/header holds:
  - state codes ESTADO_INICIAL..ESTADO_FIM (4-bit);
  - MINIGAME_MENU=2'b11;
  - game indices JOGO_0..JOGO_2.
- These are shared because the multiplexer and display decoder use them too.
- One sub-module: detector_borda (single-bit rising-edge detector with async active-low reset), instantiated four times.

Test Plan:
- Reset release -> minigame=2'b11, estado_inicial=4'h0, reset_jogos=1, cursor=0.
- proximo pulse (INICIAL->MENU), then 3 proximo pulses -> cursor 1,2,0 (wrap); then anterior -> cursor=2.
- From MENU with cursor=1: confirma, confirma -> estado 4'h3, minigame=2'b01, iniciar_jogo high for exactly 1 cycle, reset_jogos=0.
- In JOGANDO: pronto=1 -> estado 4'h4, minigame stays 2'b01. With AUTO_RETURN_EN and TEMPO_FIM=8: after 8 cycles -> estado 4'h1, minigame=2'b11, cursor=1.
- In JOGANDO: pronto and voltar in the same cycle -> MENU, not FIM. Holding botao_proximo high for 20 cycles in MENU -> cursor advances by exactly 1.
- reset pulled low mid-JOGANDO, between clock edges -> outputs return to reset values immediately without waiting for a clock edge.
